// File: rtl/miriscv_apb_bridge.sv
// Core data port to APB4 bridge. Each request is decoded against NSLV base/mask slots.
// A hit runs a full SETUP/ACCESS sequence, which may be cut short by a watchdog timeout.
// A miss returns an error response without any APB activity.
module miriscv_apb_bridge #(
  parameter int unsigned          NSLV     = 2,
  parameter int unsigned          AW       = 32,
  parameter logic [NSLV*32-1:0]   SLV_BASE = {32'h80001000, 32'h80000000},
  parameter logic [NSLV*32-1:0]   SLV_MASK = {32'hFFFFF000, 32'hFFFFF000},
  parameter int unsigned          TIMEOUT  = 255
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  // Core data port
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  // APB4 master
  output logic [NSLV-1:0]      psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [AW-1:0]        paddr_o,
  output logic [31:0]          pwdata_o,
  output logic [3:0]           pstrb_o,
  input  logic [NSLV*32-1:0]   prdata_i,
  input  logic [NSLV-1:0]      pready_i,
  input  logic [NSLV-1:0]      pslverr_i
);

  localparam int unsigned IdxW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [CntW-1:0]   cnt_q;
  logic              gnt_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [NSLV-1:0]   psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [AW-1:0]     paddr_q;
  logic [31:0]       pwdata_q;
  logic [3:0]        pstrb_q;

  logic              hit;
  logic [IdxW-1:0]   hit_idx;
  logic [NSLV-1:0]   hit_onehot;
  logic              sel_ready;
  logic              sel_err;
  logic [31:0]       sel_rdata;
  logic              tmo_expire;

  // Address decode: scanning from the top down leaves the lowest matching slot in hit_idx
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((data_addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  // One-hot select for the decoded slot
  always_comb begin
    hit_onehot = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      hit_onehot[i] = hit && (hit_idx == IdxW'(i));
    end
  end

  // Response mux from the registered slot index
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_ready = pready_i[i];
        sel_err   = pslverr_i[i];
        sel_rdata = prdata_i[32*i +: 32];
      end
    end
  end

  // The counter holds the number of ACCESS cycles already spent, so the abort fires in the
  // TIMEOUT-th ACCESS cycle. A PREADY in that same cycle still takes priority.
  assign tmo_expire = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Bridge FSM with all outputs registered
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (data_req_i) begin
            gnt_q    <= 1'b0;
            idx_q    <= hit_idx;
            pwrite_q <= data_we_i;
            paddr_q  <= data_addr_i[AW-1:0];
            pwdata_q <= data_wdata_i;
            pstrb_q  <= data_we_i ? data_be_i : 4'b0000;
            if (hit) begin
              psel_q  <= hit_onehot;
              state_q <= StSetup;
            end else begin
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= '0;
              state_q  <= StResp;
            end
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          cnt_q <= cnt_q + 1'b1;
          if (sel_ready || tmo_expire) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b1;
            err_q     <= sel_ready ? sel_err : 1'b1;
            rdata_q   <= (sel_ready && !pwrite_q) ? sel_rdata : 32'h0;
            state_q   <= StResp;
          end
        end
        StResp: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
          cnt_q    <= '0;
          gnt_q    <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_gnt_o    = gnt_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;

endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// Self-checking bench for miriscv_apb_bridge: directed cases, randomized transactions against
// a transaction-level reference model, and a reset asserted in the middle of a transfer.
module tb_miriscv_apb_bridge;

  localparam int unsigned NSLV = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned TMO  = 4;
  // Slot 1 covers 0x8000_xxxx and overlaps slot 0 (0x8000_0xxx); slot 0 must win the overlap
  localparam logic [63:0] BASE = {32'h80000000, 32'h80000000};
  localparam logic [63:0] MASK = {32'hFFFF0000, 32'hFFFFF000};

  logic              clk;
  logic              arstn;
  logic              data_req;
  logic              data_gnt;
  logic              data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_addr;
  logic [31:0]       data_wdata;
  logic              data_rvalid;
  logic [31:0]       data_rdata;
  logic              data_err;
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [NSLV*32-1:0] prdata;
  logic [NSLV-1:0]   pready;
  logic [NSLV-1:0]   pslverr;

  int checks   = 0;
  int failures = 0;

  miriscv_apb_bridge #(
    .NSLV     (NSLV),
    .AW       (AW),
    .SLV_BASE (BASE),
    .SLV_MASK (MASK),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .data_req_i    (data_req),
    .data_gnt_o    (data_gnt),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .psel_o        (psel),
    .penable_o     (penable),
    .pwrite_o      (pwrite),
    .paddr_o       (paddr),
    .pwdata_o      (pwdata),
    .pstrb_o       (pstrb),
    .prdata_i      (prdata),
    .pready_i      (pready),
    .pslverr_i     (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first slot whose masked address equals its base, or -1 on a miss
  function automatic int model_slot(input logic [31:0] a);
    logic [63:0] b;
    logic [63:0] m;
    b = BASE;
    m = MASK;
    for (int i = 0; i < int'(NSLV); i++) begin
      if ((a & m[32*i +: 32]) == b[32*i +: 32]) return i;
    end
    return -1;
  endfunction

  // Issue one request and follow it to completion. wait_n is the number of ACCESS cycles the
  // addressed slave holds PREADY low before raising it.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata, input int wait_n,
                         input logic [31:0] rd, input logic slverr);
    int          slot;
    int          exp_cyc;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [NSLV-1:0] exp_psel;
    int          cyc;
    int          got;
    logic [31:0] got_rd;
    logic        got_err;
    int          bad_apb;
    int          bad_rsp;
    int          bad_gnt;

    slot = model_slot(addr);
    if (slot < 0) begin
      exp_cyc = 1; exp_err = 1'b1; exp_rd = 32'h0; exp_psel = '0;
    end else begin
      exp_psel = '0;
      exp_psel[slot] = 1'b1;
      if (TMO != 0 && wait_n >= int'(TMO)) begin
        exp_cyc = 2 + int'(TMO); exp_err = 1'b1; exp_rd = 32'h0;
      end else begin
        exp_cyc = 3 + wait_n; exp_err = slverr; exp_rd = we ? 32'h0 : rd;
      end
    end

    chk({tag, "_gnt_idle"}, 64'(data_gnt), 64'd1);
    data_req   = 1'b1;
    data_addr  = addr;
    data_we    = we;
    data_be    = be;
    data_wdata = wdata;
    @(posedge clk); #1;
    // Scramble the request lines: the bridge must work from its latched copies
    data_req   = 1'b0;
    data_addr  = $urandom;
    data_we    = 1'($urandom);
    data_be    = 4'($urandom);
    data_wdata = $urandom;

    cyc = 1; got = -1; got_rd = 'x; got_err = 1'bx;
    bad_apb = 0; bad_rsp = 0; bad_gnt = 0;
    while (got < 0 && cyc <= 300) begin
      if (data_gnt !== 1'b0) bad_gnt++;
      if (data_rvalid === 1'b1) begin
        got = cyc; got_rd = data_rdata; got_err = data_err;
        if (psel !== '0 || penable !== 1'b0) bad_apb++;
      end else begin
        if (data_rdata !== 32'h0 || data_err !== 1'b0) bad_rsp++;
        if (slot >= 0) begin
          if (psel !== exp_psel || penable !== (cyc >= 2) || paddr !== addr ||
              pwrite !== we || pwdata !== wdata || pstrb !== (we ? be : 4'b0000))
            bad_apb++;
        end else if (psel !== '0 || penable !== 1'b0) begin
          bad_apb++;
        end
      end
      // Slave model: unaddressed slots drive noise, the addressed one follows wait_n
      prdata  = {$urandom, $urandom};
      pready  = NSLV'($urandom);
      pslverr = NSLV'($urandom);
      if (slot >= 0) begin
        pready[slot]           = (cyc - 2 == wait_n);
        pslverr[slot]          = slverr;
        prdata[32*slot +: 32]  = rd;
      end
      @(posedge clk); #1;
      cyc++;
    end
    pready = '0; pslverr = '0; prdata = '0;

    chk({tag, "_rvalid_cycle"}, 64'(got), 64'(exp_cyc));
    chk({tag, "_rdata"}, 64'(got_rd), 64'(exp_rd));
    chk({tag, "_err"}, 64'(got_err), 64'(exp_err));
    chk({tag, "_apb_seq_bad"}, 64'(bad_apb), 64'd0);
    chk({tag, "_rsp_idle_bad"}, 64'(bad_rsp), 64'd0);
    chk({tag, "_gnt_busy_bad"}, 64'(bad_gnt), 64'd0);
    chk({tag, "_rvalid_pulse"}, 64'(data_rvalid), 64'd0);
    chk({tag, "_gnt_after"}, 64'(data_gnt), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          r;

    arstn = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = '0;
    data_addr = '0; data_wdata = '0; prdata = '0; pready = '0; pslverr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(data_gnt), 64'd1);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rvalid", 64'(data_rvalid), 64'd0);
    chk("rst_rdata", 64'(data_rdata), 64'd0);
    chk("rst_err", 64'(data_err), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    arstn = 1'b1;
    @(posedge clk); #1;

    run_txn("rd_slot0", 32'h80000004, 1'b0, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    run_txn("wr_wait3", 32'h80001008, 1'b1, 4'b0011, 32'h12345678, 3, 32'hCAFEF00D, 1'b0);
    run_txn("miss", 32'h00004000, 1'b0, 4'hF, 32'h0, 0, 32'h11111111, 1'b0);
    run_txn("slverr", 32'h80000010, 1'b0, 4'hF, 32'h0, 0, 32'hA5A51234, 1'b1);
    run_txn("timeout", 32'h80001000, 1'b0, 4'hF, 32'h0, 20, 32'h22222222, 1'b0);
    run_txn("ready_at_tmo", 32'h80001000, 1'b0, 4'hF, 32'h0, 3, 32'h33333333, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       a = 32'h80000000 | ($urandom & 32'h00000FFC);
        1:       a = 32'h80001000 | ($urandom & 32'h00000FFC);
        2:       a = 32'h80000000 | ($urandom & 32'h0000FFFC);
        default: a = $urandom & 32'hFFFFFFFC;
      endcase
      run_txn("rand", a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 6),
              $urandom, 1'($urandom));
    end

    // Reset in the middle of an ACCESS phase
    data_req = 1'b1; data_addr = 32'h80000020; data_we = 1'b0; data_be = 4'hF;
    @(posedge clk); #1;
    data_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pre_penable", 64'(penable), 64'd1);
    #2;
    arstn = 1'b0;
    #1;
    chk("midrst_psel", 64'(psel), 64'd0);
    chk("midrst_penable", 64'(penable), 64'd0);
    chk("midrst_rvalid", 64'(data_rvalid), 64'd0);
    chk("midrst_gnt", 64'(data_gnt), 64'd1);
    @(posedge clk); #1;
    arstn = 1'b1;
    @(posedge clk); #1;
    chk("postrst_rvalid", 64'(data_rvalid), 64'd0);
    run_txn("postrst_rd", 32'h80000008, 1'b0, 4'hF, 32'h0, 1, 32'h0BADC0DE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_apb_bridge.md
Name: miriscv_apb_bridge

Overview:
- Parametrised bridge from the core data port to NSLV APB4 peripheral slots; the SoC instantiates it and drops its fixed two-slave decode.
- Adds a configurable base/mask address map, a full two-phase APB SETUP/ACCESS sequence, PREADY wait states, PSLVERR propagation and a watchdog timeout.
- A request that hits no slot returns an error response.

Parameters:
- NSLV, 2, number of APB slave slots (1..8).
- AW, 32, PADDR width; the latched address is truncated to AW bits.
- SLV_BASE, {32'h80001000, 32'h80000000}, packed NSLV*32 base addresses; slot i occupies bits [32*i+31:32*i].
- SLV_MASK, {32'hFFFFF000, 32'hFFFFF000}, packed NSLV*32 decode masks.
- TIMEOUT, 255, number of ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  asynchronous active-low reset.
- data_req_i  in  1  request from core.
- data_gnt_o  out  1  bridge idle; request accepted when data_req_i & data_gnt_o.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  one-cycle completion pulse.
- data_rdata_o  out  32  read data, valid with data_rvalid_o.
- data_err_o  out  1  error flag, valid with data_rvalid_o.
- psel_o  out  NSLV  one-hot APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB write.
- paddr_o  out  AW  APB address.
- pwdata_o  out  32  APB write data.
- pstrb_o  out  4  APB4 strobes.
- prdata_i  in  NSLV*32  packed slave read data.
- pready_i  in  NSLV  slave ready.
- pslverr_i  in  NSLV  slave error.

Behaviour:
- Reset (async, arstn_i low):
  - FSM goes to IDLE.
  - All outputs are 0 except data_gnt_o=1.
  - The timeout counter is 0.
  - A reset mid-transfer drops psel_o and penable_o immediately; no rvalid is issued for the aborted transfer.
- Decode:
  - Slot i hits when (addr & SLV_MASK[i]) == SLV_BASE[i].
  - Lowest index wins when several slots hit.
  - Decode runs on data_addr_i at acceptance; the resulting index is registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - data_gnt_o=1.
  - On acceptance, latch addr, we, be and wdata.
  - Hit: go to SETUP.
  - Miss: go to RESP with err=1, rdata=0; no APB activity.
  - data_req_i while not in IDLE is ignored. The core must hold req until gnt.
- SETUP (1 cycle):
  - psel_o[idx]=1, penable_o=0.
  - paddr_o, pwrite_o, pwdata_o and pstrb_o are driven from the latches.
  - pstrb_o = be on writes, 4'b0 on reads.
  - Always go to ACCESS.
- ACCESS:
  - psel held, penable_o=1, timeout counter increments each cycle.
  - On pready_i[idx]=1: capture rdata = prdata[idx] on reads (0 on writes) and err = pslverr_i[idx]; go to RESP.
  - Timeout: when TIMEOUT≠0 and the counter reaches TIMEOUT with pready low, abort with err=1, rdata=0, go to RESP.
  - pready wins if it arrives in the same cycle as the timeout.
- RESP (1 cycle):
  - data_rvalid_o=1; data_rdata_o and data_err_o carry the captured values.
  - psel_o=0, penable_o=0, counter cleared.
  - data_gnt_o=0; next state is IDLE.
- Outside RESP, data_rvalid_o=0, data_err_o=0, data_rdata_o=0.
- APB address/data outputs hold stable throughout SETUP and ACCESS; their value is don't-care in IDLE.
- Latency, counting the acceptance cycle as 0:
  - Zero-wait hit: SETUP in cycle 1, ACCESS in cycle 2, RESP/rvalid in cycle 3.
  - Each wait state adds 1 cycle.
  - Miss: rvalid in cycle 1.
  - Timeout: rvalid in cycle 2+TIMEOUT.
  - Back-to-back requests: next acceptance no earlier than cycle 4.

Test Plan:
- Read 0x80000004, slot0 prdata=0xDEADBEEF, pready=1 → psel_o=01 (penable 0) in cycle 1, penable 1 in cycle 2; rvalid cycle 3 with rdata=0xDEADBEEF, err=0.
- Write 0x80001008, wdata=0x12345678, be=4'b0011; slot1 pready low 3 cycles → pwdata=0x12345678, pstrb=0011, paddr=0x80001008 stable; rvalid in cycle 6 with rdata=0.
- Access 0x00004000 (no hit) → no psel; rvalid cycle 1 with err=1, rdata=0.
- Slot0 read returns pslverr=1 with pready=1 → err=1 on rvalid; rdata equals prdata.
- TIMEOUT=4, slot1 pready stuck low → ACCESS for 4 cycles then psel drops; rvalid in cycle 6 with err=1. Rerun with pready rising in ACCESS cycle 4 → err=0.
- Assert arstn_i low during ACCESS → psel_o, penable_o and rvalid go 0 asynchronously; after release gnt=1 and a new read completes normally.
